// File: rtl/y_demux4_reg.sv
// Registered 1-to-4 demux: one-entry holding register per channel, one cycle in-to-out latency.
// in_ready stalls only when the addressed channel is full and its consumer is not taking it.
module y_demux4_reg #(
  parameter int SIZE  = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SIZE-1:0]   in_data,
  input  logic [1:0]        in_sel,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready,
  output logic [4*SIZE-1:0] out_data,
  output logic [CNT_W-1:0]  accept_cnt,
  output logic              busy
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ch_state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ch_state_t       state_q [4];
  ch_state_t       state_nxt [4];
  logic [SIZE-1:0] d_q [4];
  logic [3:0]      v;
  logic [3:0]      load;
  logic [3:0]      drain;
  logic            accept;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      v[i] = (state_q[i] == FULL);
    end
  end

  // Ready looks only at the addressed channel, never at in_valid.
  assign in_ready  = ~v[in_sel] | out_ready[in_sel];
  assign accept    = in_valid & in_ready;
  assign out_valid = v;
  assign busy      = |v;

  always_comb begin
    load  = 4'b0000;
    drain = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      load[i]  = accept & (in_sel == 2'(i));
      drain[i] = v[i] & out_ready[i];
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_nxt[i] = state_q[i];
      case (state_q[i])
        EMPTY:   if (load[i]) state_nxt[i] = FULL;
        FULL:    if (drain[i] && !load[i]) state_nxt[i] = EMPTY;
        default: state_nxt[i] = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= EMPTY;
        d_q[i]     <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_nxt[i];
        if (load[i]) d_q[i] <= in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accept_cnt <= '0;
    end else if (accept) begin
      accept_cnt <= accept_cnt + CNT_ONE;
    end
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < 4; i++) begin
      out_data[i*SIZE +: SIZE] = d_q[i];
    end
  end

endmodule

// File: tb/tb_y_demux4_reg.sv
// Bench for y_demux4_reg: queue-per-channel reference plus directed literal checks.
// A second instance with a 4-bit counter shares all inputs to exercise counter wrap.
module tb_y_demux4_reg;

  localparam int SIZE = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [SIZE-1:0]  in_data;
  logic [1:0]       in_sel;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [4*SIZE-1:0] out_data;
  logic [15:0]      accept_cnt;
  logic             busy;

  logic             s_in_ready;
  logic [3:0]       s_out_valid;
  logic [4*SIZE-1:0] s_out_data;
  logic [3:0]       s_accept_cnt;
  logic             s_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  y_demux4_reg #(.SIZE(SIZE), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .accept_cnt(accept_cnt), .busy(busy)
  );

  y_demux4_reg #(.SIZE(SIZE), .CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .accept_cnt(s_accept_cnt), .busy(s_busy)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each channel is a queue of at most one pending word.
  logic [SIZE-1:0] mq [4][$];
  int unsigned     mcnt;

  function automatic bit model_ready();
    return (mq[in_sel].size() == 0) || out_ready[in_sel];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) mq[i].delete();
      mcnt = 0;
    end else begin
      bit acc;
      acc = in_valid && model_ready();
      for (int i = 0; i < 4; i++)
        if (mq[i].size() > 0 && out_ready[i]) void'(mq[i].pop_front());
      if (acc) begin
        mq[in_sel].push_back(in_data);
        mcnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("m_in_ready", {127'b0, in_ready}, {127'b0, model_ready()});
      chk("m_cnt", {112'b0, accept_cnt}, {112'b0, mcnt[15:0]});
      chk("m_cnt_small", {124'b0, s_accept_cnt}, {124'b0, mcnt[3:0]});
      chk("m_busy", {127'b0, busy}, {127'b0, (mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size()) != 0});
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("m_valid%0d", i), {127'b0, out_valid[i]}, {127'b0, mq[i].size() != 0});
        if (mq[i].size() != 0)
          chk($sformatf("m_data%0d", i), {96'b0, out_data[i*SIZE +: SIZE]}, {96'b0, mq[i][0]});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 4'b0000;
    #2;
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic ch(input int i, output logic [SIZE-1:0] w);
    w = out_data[i*SIZE +: SIZE];
  endtask

  logic [SIZE-1:0] w;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = 2'd0; out_ready = 4'b0000;
    #12;
    chk("rst_valid", {124'b0, out_valid}, 128'h0);
    chk("rst_data", out_data, 128'h0);
    chk("rst_cnt", {112'b0, accept_cnt}, 128'h0);
    chk("rst_busy", {127'b0, busy}, 128'h0);
    chk("rst_in_ready", {127'b0, in_ready}, 128'h1);
    rst_n = 1'b1;
    cyc();

    // Single routing
    in_sel = 2'd1; in_data = 32'hDEADBEEF; in_valid = 1'b1; #1;
    chk("route_in_ready", {127'b0, in_ready}, 128'h1);
    cyc(); in_valid = 1'b0; #1;
    chk("route_valid", {124'b0, out_valid}, 128'h2);
    chk("route_data", out_data, {64'h0, 32'hDEADBEEF, 32'h0});
    chk("route_cnt", {112'b0, accept_cnt}, 128'd1);
    out_ready = 4'b0010; cyc(); out_ready = 4'b0000;

    // Backpressure on channel 3
    in_sel = 2'd3; in_data = 32'h12345678; in_valid = 1'b1; cyc();
    in_data = 32'hCAFEF00D; #1;
    chk("bp_in_ready_low", {127'b0, in_ready}, 128'h0);
    repeat (5) cyc();
    ch(3, w);
    chk("bp_hold_data", {96'b0, w}, {96'b0, 32'h12345678});
    chk("bp_hold_cnt", {112'b0, accept_cnt}, 128'd2);
    out_ready = 4'b1000; #1;
    chk("bp_in_ready_high", {127'b0, in_ready}, 128'h1);
    cyc(); in_valid = 1'b0; out_ready = 4'b0000; #1;
    ch(3, w);
    chk("bp_new_data", {96'b0, w}, {96'b0, 32'hCAFEF00D});
    chk("bp_valid3", {127'b0, out_valid[3]}, 128'h1);
    chk("bp_cnt", {112'b0, accept_cnt}, 128'd3);
    out_ready = 4'b1000; cyc(); out_ready = 4'b0000;

    // Stall isolation: channel 0 full and stalled
    in_sel = 2'd0; in_data = 32'hA0A0A0A0; in_valid = 1'b1; cyc();
    for (int s = 1; s < 4; s++) begin
      in_sel = 2'(s); in_data = {4{8'(s * 8'h11)}}; #1;
      chk("iso_in_ready", {127'b0, in_ready}, 128'h1);
      cyc();
      ch(0, w);
      chk("iso_ch0", {96'b0, w}, {96'b0, 32'hA0A0A0A0});
    end
    in_valid = 1'b0; #1;
    chk("iso_valid", {124'b0, out_valid}, 128'hF);
    chk("iso_data", out_data, {32'h33333333, 32'h22222222, 32'h11111111, 32'hA0A0A0A0});
    chk("iso_cnt", {112'b0, accept_cnt}, 128'd7);
    out_ready = 4'b1111; cyc(); out_ready = 4'b0000; #1;
    chk("iso_drained", {124'b0, out_valid}, 128'h0);

    // Reset mid-traffic
    in_valid = 1'b1; in_sel = 2'd0; in_data = 32'h55; cyc();
    in_sel = 2'd2; in_data = 32'h66; cyc();
    in_valid = 1'b0; #2;
    rst_n = 1'b0; #1;
    chk("mid_rst_valid", {124'b0, out_valid}, 128'h0);
    chk("mid_rst_data", out_data, 128'h0);
    chk("mid_rst_cnt", {112'b0, accept_cnt}, 128'h0);
    chk("mid_rst_busy", {127'b0, busy}, 128'h0);
    chk("mid_rst_in_ready", {127'b0, in_ready}, 128'h1);
    @(negedge clk); rst_n = 1'b1; cyc();
    in_valid = 1'b1; in_sel = 2'd2; in_data = 32'h77; cyc();
    in_valid = 1'b0; #1;
    chk("post_rst_valid", {124'b0, out_valid}, 128'h4);
    chk("post_rst_data", out_data, {32'h0, 32'h77, 64'h0});
    chk("post_rst_cnt", {112'b0, accept_cnt}, 128'd1);

    // Streaming at full rate
    do_reset();
    out_ready = 4'b1111; in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      in_sel = 2'($urandom_range(0, 3)); in_data = $urandom(); #1;
      chk("stream_in_ready", {127'b0, in_ready}, 128'h1);
      cyc();
    end
    in_valid = 1'b0; #1;
    chk("stream_cnt", {112'b0, accept_cnt}, 128'd100);
    cyc(); out_ready = 4'b0000;

    // Counter wrap on the 4-bit instance
    do_reset();
    out_ready = 4'b1111; in_valid = 1'b1; in_sel = 2'd0;
    for (int k = 1; k <= 17; k++) begin
      in_data = k; cyc();
      if (k == 15) chk("wrap_15", {124'b0, s_accept_cnt}, 128'd15);
      if (k == 16) chk("wrap_16", {124'b0, s_accept_cnt}, 128'd0);
      if (k == 17) chk("wrap_17", {124'b0, s_accept_cnt}, 128'd1);
    end
    in_valid = 1'b0;
    cyc(); out_ready = 4'b0000; cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
